alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU controller, plus the two forwarded operands.
- Single-cycle ops (AND/OR/ADD/SUB/SLT) return a registered result after 1 cycle.
- MUL (code 4'b1000) runs as an iterative shift-add multiplier, holding busy_o high so the hazard unit stalls IF/ID/EX.
- Sits between the forwarding muxes and the EX/MEM pipeline register.

---
 rtl/alu_ctrl_pkg.sv | 18 +
 rtl/alu_exec_unit_mul_iter.sv | 22 ++
 rtl/alu_exec_unit.sv | 160 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions.
// Holds the 4-bit ALU control codes produced by the ALU controller and the
// execute-unit state encoding. Also imported by the hazard unit.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_mul_iter.sv
// mul_iter: one shift-add multiply iteration, purely combinational.
// Ports:
//   acc, mcand, mplier                 current accumulator / multiplicand / multiplier
//   acc_next, mcand_next, mplier_next  values after one iteration
// Only the low DW bits of the product are kept, so the accumulator and the
// left-shifted multiplicand are both truncated to DW bits.
module mul_iter #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] mcand,
    input  logic [DW-1:0] mplier,
    output logic [DW-1:0] acc_next,
    output logic [DW-1:0] mcand_next,
    output logic [DW-1:0] mplier_next
);

    assign acc_next    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_next  = {mcand[DW-2:0], 1'b0};
    assign mplier_next = {1'b0, mplier[DW-1:1]};

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU.
// Single-cycle AND/OR/ADD/SUB/SLT return a registered result one cycle after
// acceptance; MUL runs as an iterative shift-add multiplier with busy_o high.
// Optional feature macro: ALU_MUL_EARLY_TERM_EN (finish a MUL as soon as the
// remaining multiplier is zero; otherwise every MUL takes DW iterations).
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous active-low reset
//   valid_i   operation present this cycle (ignored while busy_o)
//   flush_i   kill in-flight or incoming op
//   ctrl_i    4-bit ALU control code
//   src1_i    operand A
//   src2_i    operand B / multiplier
//   result_o  registered result
//   zero_o    registered (result_o == 0)
//   valid_o   one-cycle pulse when result_o/zero_o are updated
//   busy_o    high while a MUL is iterating
//
// state   | meaning
// ST_IDLE | ready to accept a new op
// ST_MUL  | shift-add multiply iterating, busy_o high
module alu_exec_unit
    import alu_ctrl_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic          flush_i,
    input  logic [3:0]    ctrl_i,
    input  logic [DW-1:0] src1_i,
    input  logic [DW-1:0] src2_i,
    output logic [DW-1:0] result_o,
    output logic          zero_o,
    output logic          valid_o,
    output logic          busy_o
);

    alu_state_e    state, state_nxt;
    logic [DW-1:0] acc, acc_nxt;
    logic [DW-1:0] mcand, mcand_nxt;
    logic [DW-1:0] mplier, mplier_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [DW-1:0] result_nxt;
    logic          zero_nxt;
    logic          valid_nxt;
    logic          busy_nxt;

    logic [DW-1:0] acc_iter, mcand_iter, mplier_iter;
    logic [DW-1:0] alu_res;
    logic          mul_done;

    mul_iter #(.DW(DW)) u_mul_iter (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_iter),
        .mcand_next  (mcand_iter),
        .mplier_next (mplier_iter)
    );

    // Unknown codes fall through to zero so the pipeline still sees a pulse.
    always_comb begin
        alu_res = '0;
        case (ctrl_i)
            ALU_AND: alu_res = src1_i & src2_i;
            ALU_OR:  alu_res = src1_i | src2_i;
            ALU_ADD: alu_res = src1_i + src2_i;
            ALU_SUB: alu_res = src1_i - src2_i;
            ALU_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            default: alu_res = '0;
        endcase
    end

    // Completion is judged on the iteration being performed this edge.
`ifdef ALU_MUL_EARLY_TERM_EN
    assign mul_done = (mplier_iter == '0);
`else
    assign mul_done = (cnt == CNT_W'(DW-1));
`endif

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        cnt_nxt    = cnt;
        result_nxt = result_o;
        zero_nxt   = zero_o;
        valid_nxt  = 1'b0;
        busy_nxt   = busy_o;
        case (state)
            ST_IDLE: begin
                if (valid_i && !flush_i) begin
                    if (ctrl_i == ALU_MUL) begin
                        state_nxt  = ST_MUL;
                        acc_nxt    = '0;
                        mcand_nxt  = src1_i;
                        mplier_nxt = src2_i;
                        cnt_nxt    = '0;
                        busy_nxt   = 1'b1;
                    end else begin
                        result_nxt = alu_res;
                        zero_nxt   = (alu_res == '0);
                        valid_nxt  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (flush_i) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    acc_nxt    = acc_iter;
                    mcand_nxt  = mcand_iter;
                    mplier_nxt = mplier_iter;
                    cnt_nxt    = cnt + CNT_W'(1);
                    if (mul_done) begin
                        state_nxt  = ST_IDLE;
                        result_nxt = acc_iter;
                        zero_nxt   = (acc_iter == '0);
                        valid_nxt  = 1'b1;
                        busy_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            result_o <= '0;
            zero_o   <= 1'b1;
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            mcand    <= mcand_nxt;
            mplier   <= mplier_nxt;
            cnt      <= cnt_nxt;
            result_o <= result_nxt;
            zero_o   <= zero_nxt;
            valid_o  <= valid_nxt;
            busy_o   <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
// Honours ALU_MUL_EARLY_TERM_EN when computing expected MUL latencies.
module tb_alu_exec_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        flush_i;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        valid_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    alu_exec_unit #(.DW(32), .CNT_W(6)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .flush_i  (flush_i),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int mul_iters(input logic [31:0] b);
`ifdef ALU_MUL_EARLY_TERM_EN
        int n = 1;
        for (int i = 0; i < 32; i++)
            if (b[i]) n = i + 1;
        return n;
`else
        return 32;
`endif
    endfunction

    task automatic single_op(input string tag, input logic [3:0] c,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
        valid_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b;
        tick();
        valid_i = 1'b0;
        check_val({tag, "_valid"}, 32'(valid_o), 32'd1);
        check_val({tag, "_res"}, result_o, exp);
        check_val({tag, "_zero"}, 32'(zero_o), 32'(exp == 32'd0));
        tick();
        check_val({tag, "_pulse_end"}, 32'(valid_o), 32'd0);
    endtask

    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit hold_add);
        int n;
        bit early_pulse;
        valid_i = 1'b1; ctrl_i = 4'b1000; src1_i = a; src2_i = b;
        tick();
        if (hold_add) begin
            ctrl_i = 4'b0010; src1_i = 32'd2; src2_i = 32'd3;
        end else begin
            valid_i = 1'b0;
        end
        check_val({tag, "_busy_start"}, 32'(busy_o), 32'd1);
        n = 0;
        early_pulse = 1'b0;
        while (busy_o && n < 200) begin
            if (valid_o) early_pulse = 1'b1;
            n++;
            tick();
        end
        check_val({tag, "_busy_cycles"}, 32'(n), 32'(mul_iters(b)));
        check_val({tag, "_no_early_valid"}, 32'(early_pulse), 32'd0);
        check_val({tag, "_valid"}, 32'(valid_o), 32'd1);
        check_val({tag, "_res"}, result_o, exp);
        check_val({tag, "_zero"}, 32'(zero_o), 32'(exp == 32'd0));
        tick();
        if (hold_add) begin
            check_val({tag, "_held_add_valid"}, 32'(valid_o), 32'd1);
            check_val({tag, "_held_add_res"}, result_o, 32'd5);
            valid_i = 1'b0;
            tick();
        end
        check_val({tag, "_pulse_end"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b0; valid_i = 1'b1; flush_i = 1'b0;
        ctrl_i = 4'b0010; src1_i = 32'd1; src2_i = 32'd2;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("rst_result", result_o, 32'd0);
            check_val("rst_zero", 32'(zero_o), 32'd1);
            check_val("rst_valid", 32'(valid_o), 32'd0);
            check_val("rst_busy", 32'(busy_o), 32'd0);
        end
        valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        check_val("idle_valid", 32'(valid_o), 32'd0);

        single_op("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        single_op("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0);
        single_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
        single_op("slt_pos", 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0);
        single_op("and", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        single_op("or", 4'b0001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
        single_op("bad_code", 4'b0101, 32'h1234_5678, 32'h1111_1111, 32'd0);

        run_mul("mul_shift", 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 1'b1);
        run_mul("mul_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_mul("mul_3x5", 32'd3, 32'd5, 32'd15, 1'b0);
        run_mul("mul_x0", 32'h0000_0007, 32'd0, 32'd0, 1'b0);

        // Flush at iteration 10 leaves the previous result (5) untouched.
        single_op("pre_flush_add", 4'b0010, 32'd2, 32'd3, 32'd5);
        valid_i = 1'b1; ctrl_i = 4'b1000; src1_i = 32'h0000_0003; src2_i = 32'h8000_0001;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_val("flush_busy_before", 32'(busy_o), 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_val("flush_busy", 32'(busy_o), 32'd0);
        check_val("flush_valid", 32'(valid_o), 32'd0);
        check_val("flush_result", result_o, 32'd5);
        for (int i = 0; i < 3; i++) tick();
        check_val("flush_valid_later", 32'(valid_o), 32'd0);

        valid_i = 1'b1; flush_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'd1; src2_i = 32'd1;
        tick();
        valid_i = 1'b0; flush_i = 1'b0;
        check_val("idle_flush_valid", 32'(valid_o), 32'd0);
        check_val("idle_flush_result", result_o, 32'd5);
        tick();
        check_val("idle_flush_valid2", 32'(valid_o), 32'd0);

        // Reset at iteration 5.
        valid_i = 1'b1; ctrl_i = 4'b1000; src1_i = 32'd9; src2_i = 32'hFFFF_FFFF;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        check_val("midrst_busy", 32'(busy_o), 32'd0);
        check_val("midrst_result", result_o, 32'd0);
        check_val("midrst_zero", 32'(zero_o), 32'd1);
        check_val("midrst_valid", 32'(valid_o), 32'd0);
        tick();
        check_val("midrst_valid2", 32'(valid_o), 32'd0);
        check_val("midrst_busy2", 32'(busy_o), 32'd0);
        single_op("post_rst_add", 4'b0010, 32'd2, 32'd3, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
